// File: rtl/maxpool_window_reader_if.sv
// maxpool_window_reader_if: control and buffer bus of the max-pool reader.
// master = pooling engine, slave = buffer/sequencer side.
interface maxpool_window_reader_if #(
   parameter int DATA_WIDTH = 20,
   parameter int IMG_W_LOG2 = 6
);
   logic                         start;
   logic                         busy;
   logic                         done;
   logic                         crd;
   logic [2*IMG_W_LOG2-1:0]      caddr_rd;
   logic signed [DATA_WIDTH-1:0] cdata_rd;
   logic                         cwr;
   logic [2*IMG_W_LOG2-3:0]      caddr_wr;
   logic signed [DATA_WIDTH-1:0] cdata_wr;
   logic [2:0]                   csel;

   modport master (
      input  start, cdata_rd,
      output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
   );

   modport slave (
      output start, cdata_rd,
      input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
   );
endinterface

// File: rtl/maxpool_window_reader.sv
// maxpool_window_reader: 2x2/stride-2 signed max-pool, one sample per cycle.
// Define MAXPOOL_RELU_CLAMP_EN to write negative maxima as zero.
module maxpool_window_reader #(
   parameter int         DATA_WIDTH = 20,
   parameter int         IMG_W_LOG2 = 6,
   parameter logic [2:0] SEL_RD     = 3'b001,
   parameter logic [2:0] SEL_WR     = 3'b011
) (
   input logic                     clk,
   input logic                     reset_n,
   maxpool_window_reader_if.master bus
);
   localparam int PW = IMG_W_LOG2 - 1;

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

   state_t                       state_q, state_d;
   logic [1:0]                   k_q, k_d;
   logic [PW-1:0]                prow_q, prow_d;
   logic [PW-1:0]                pcol_q, pcol_d;
   logic signed [DATA_WIDTH-1:0] max_q, max_d;
   logic signed [DATA_WIDTH-1:0] wval;
   logic                         cap_en, cap_first;

   logic                         busy_d, done_d, crd_d, cwr_d;
   logic [2*IMG_W_LOG2-1:0]      ard_d;
   logic [2*IMG_W_LOG2-3:0]      awr_d;
   logic signed [DATA_WIDTH-1:0] dwr_d;
   logic [2:0]                   csel_d;

   // state, window position and running max
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         prow_q  <= '0;
         pcol_q  <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         prow_q  <= prow_d;
         pcol_q  <= pcol_d;
         max_q   <= max_d;
      end
   end

   // next state, window stepping and sample capture
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      prow_d  = prow_q;
      pcol_d  = pcol_q;
      // data returns one cycle after its read
      cap_en    = (state_q == RD && k_q != 2'd0) || state_q == WAIT;
      cap_first = state_q == RD && k_q == 2'd1;
      max_d     = max_q;
      if (cap_en && (cap_first || bus.cdata_rd > max_q))
         max_d = bus.cdata_rd;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RD;
               k_d     = '0;
               prow_d  = '0;
               pcol_d  = '0;
            end
         end
         RD: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3)
               state_d = WAIT;
         end
         WAIT: state_d = WR;
         WR: begin
            k_d    = '0;
            pcol_d = pcol_q + PW'(1);
            if (&pcol_q)
               prow_d = prow_q + PW'(1);
            state_d = (&pcol_q && &prow_q) ? FIN : RD;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // value written for the finished window
   always_comb begin
`ifdef MAXPOOL_RELU_CLAMP_EN
      wval = max_d[DATA_WIDTH-1] ? '0 : max_d;
`else
      wval = max_d;
`endif
   end

   // next values of the registered outputs
   always_comb begin
      crd_d  = state_d == RD;
      cwr_d  = state_d == WR;
      done_d = state_d == FIN;
      busy_d = crd_d || cwr_d || state_d == WAIT;
      ard_d  = '0;
      awr_d  = '0;
      dwr_d  = '0;
      if (crd_d)
         ard_d = {prow_d, k_d[1], pcol_d, k_d[0]};
      if (cwr_d) begin
         awr_d = {prow_d, pcol_d};
         dwr_d = wval;
      end
      unique case (1'b1)
         crd_d:   csel_d = SEL_RD;
         cwr_d:   csel_d = SEL_WR;
         default: csel_d = '0;
      endcase
   end

   // output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.crd      <= 1'b0;
         bus.caddr_rd <= '0;
         bus.cwr      <= 1'b0;
         bus.caddr_wr <= '0;
         bus.cdata_wr <= '0;
         bus.csel     <= '0;
      end else begin
         bus.busy     <= busy_d;
         bus.done     <= done_d;
         bus.crd      <= crd_d;
         bus.caddr_rd <= ard_d;
         bus.cwr      <= cwr_d;
         bus.caddr_wr <= awr_d;
         bus.cdata_wr <= dwr_d;
         bus.csel     <= csel_d;
      end
   end
endmodule

// File: tb/tb_maxpool_window_reader.sv
// tb_maxpool_window_reader: W=4 and W=64 engines vs a cycle-indexed model.
// Optional MAXPOOL_RELU_CLAMP_EN changes the expected negative maxima.
module tb_maxpool_window_reader;
   localparam int DW = 20;
`ifdef MAXPOOL_RELU_CLAMP_EN
   localparam int NEG_EXP = 0;
`else
   localparam int NEG_EXP = -1;
`endif

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 start [2];
   logic signed [DW-1:0] mem [4096];

   int checks = 0;
   int errors = 0;
   int wdat [2][1100];
   int wadr [2][1100];
   int nwr [2];
   int radr [2][16];
   int nrd [2];
   int ndone [2];
   int dlat [2];

   int ramp_d [4] = '{5, 7, 13, 15};
   int ramp_r [8] = '{0, 1, 4, 5, 2, 3, 6, 7};
   int sgn_d [4]  = '{NEG_EXP, 7, 9, 100};
   int big_r [4]  = '{0, 1, 64, 65};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   // pooled value of window w in a 2^l map, from plain arithmetic
   function automatic int wmax(input int w, input int l);
      int wd, h, r, c, m, v;
      wd = 1 << l;
      h  = wd / 2;
      r  = 2 * (w / h);
      c  = 2 * (w % h);
      m  = int'(mem[r*wd + c]);
      for (int i = 1; i < 4; i++) begin
         v = int'(mem[(r + i/2)*wd + c + i%2]);
         if (v > m) m = v;
      end
`ifdef MAXPOOL_RELU_CLAMP_EN
      if (m < 0) m = 0;
`endif
      return m;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int L  = (g == 0) ? 2 : 6;
      localparam int W  = 1 << L;
      localparam int H  = W / 2;
      localparam int NW = H * H;

      int mc    = 0;
      int lat   = 0;
      bit rz    = 1'b0;
      bit armed = 1'b0;

      maxpool_window_reader_if #(.DATA_WIDTH(DW), .IMG_W_LOG2(L)) bus ();

      maxpool_window_reader #(.DATA_WIDTH(DW), .IMG_W_LOG2(L)) dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus)
      );

      assign bus.start = start[g];

      // buffer with one-cycle read latency
      always @(posedge clk)
         if (bus.crd) bus.cdata_rd <= mem[int'(bus.caddr_rd)];

      // model: mc = cycles since accepted start, 0 when idle
      always @(posedge clk) begin
         armed <= 1'b1;
         rz    <= !reset_n;
         if (!reset_n) begin
            mc <= 0;
         end else if (mc == 0) begin
            if (start[g]) begin
               mc  <= 1;
               lat <= 2;
            end
         end else begin
            mc  <= (mc == 6*NW + 1) ? 0 : mc + 1;
            lat <= lat + 1;
         end
      end

      // compare every cycle against the model
      always @(negedge clk) begin
         int w, p, ectl, ea, ed;
         if (armed) begin
            if (rz)
               chk($sformatf("reset_zero_w%0d", W),
                   int'(|{bus.busy, bus.done, bus.crd, bus.caddr_rd,
                          bus.cwr, bus.caddr_wr, bus.cdata_wr, bus.csel}), 0);
            ectl = 0;
            ea   = 0;
            ed   = 0;
            w    = (mc - 1) / 6;
            p    = (mc - 1) % 6;
            if (mc >= 1 && mc <= 6*NW) begin
               if (p < 4) begin
                  ectl = 7'b1010001;
                  ea   = (2*(w/H) + p/2)*W + 2*(w%H) + p%2;
               end else if (p == 4) begin
                  ectl = 7'b1000000;
               end else begin
                  ectl = 7'b1001011;
                  ea   = w;
                  ed   = wmax(w, L);
               end
            end else if (mc == 6*NW + 1) begin
               ectl = 7'b0100000;
            end
            chk($sformatf("ctl_w%0d_mc%0d", W, mc),
                int'({bus.busy, bus.done, bus.crd, bus.cwr, bus.csel}), ectl);
            if (ectl == 7'b1010001)
               chk($sformatf("rd_addr_w%0d_mc%0d", W, mc),
                   int'(bus.caddr_rd), ea);
            if (ectl == 7'b1001011) begin
               chk($sformatf("wr_addr_w%0d_win%0d", W, w),
                   int'(bus.caddr_wr), ea);
               chk($sformatf("wr_data_w%0d_win%0d", W, w),
                   int'(bus.cdata_wr), ed);
            end
            if (bus.crd && nrd[g] < 16) begin
               radr[g][nrd[g]] = int'(bus.caddr_rd);
               nrd[g]++;
            end
            if (bus.cwr && nwr[g] < 1100) begin
               wadr[g][nwr[g]] = int'(bus.caddr_wr);
               wdat[g][nwr[g]] = int'(bus.cdata_wr);
               nwr[g]++;
            end
            if (bus.done) begin
               ndone[g]++;
               dlat[g] = lat;
            end
         end
      end
   end

   task automatic run(input int g, input int budget);
      int nd;
      nwr[g] = 0;
      nrd[g] = 0;
      nd     = ndone[g];
      @(negedge clk); #1 start[g] = 1'b1;
      @(negedge clk); #1 start[g] = 1'b0;
      for (int i = 0; i < budget && ndone[g] == nd; i++)
         @(negedge clk);
      chk($sformatf("done_seen_g%0d", g), ndone[g] - nd, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int nd;
      reset_n  = 1'b0;
      start[0] = 1'b0;
      start[1] = 1'b0;
      for (int a = 0; a < 4096; a++) mem[a] = '0;
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;

      // ramp map, W=4
      for (int a = 0; a < 16; a++) mem[a] = DW'(a);
      run(0, 60);
      chk("ramp_nwr", nwr[0], 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ramp_data%0d", i), wdat[0][i], ramp_d[i]);
         chk($sformatf("ramp_addr%0d", i), wadr[0][i], i);
      end
      for (int i = 0; i < 8; i++)
         chk($sformatf("ramp_rd%0d", i), radr[0][i], ramp_r[i]);
      chk("ramp_latency", dlat[0], 26);

      // signed compare, ties and max in k0
      mem[0]  = DW'(-3);  mem[1]  = DW'(-8);
      mem[4]  = DW'(-1);  mem[5]  = DW'(-20);
      mem[2]  = DW'(-5);  mem[3]  = DW'(7);
      mem[6]  = DW'(7);   mem[7]  = DW'(2);
      mem[8]  = DW'(9);   mem[9]  = DW'(9);
      mem[12] = DW'(9);   mem[13] = DW'(9);
      mem[10] = DW'(100); mem[11] = DW'(-1);
      mem[14] = DW'(50);  mem[15] = DW'(99);
      run(0, 60);
      for (int i = 0; i < 4; i++)
         chk($sformatf("signed_data%0d", i), wdat[0][i], sgn_d[i]);

      // starts while busy and during the done cycle are ignored
      nwr[0] = 0;
      nd     = ndone[0];
      @(negedge clk); #1 start[0] = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         #1 start[0] = (c == 10 || c == 25);
      end
      start[0] = 1'b0;
      chk("ignore_nwr", nwr[0], 4);
      chk("ignore_ndone", ndone[0] - nd, 1);

      // W=64 random map, aborted by reset inside window 5
      for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
      nwr[1] = 0;
      @(negedge clk); #1 start[1] = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         #1 start[1] = 1'b0;
      end
      reset_n = 1'b0;
      @(negedge clk); #1 reset_n = 1'b1;
      chk("abort_nwr", nwr[1], 5);
      repeat (3) @(negedge clk);

      // fresh full W=64 run from window (0,0)
      run(1, 7000);
      chk("full_nwr", nwr[1], 1024);
      chk("full_first_addr", wadr[1][0], 0);
      chk("full_last_addr", wadr[1][1023], 1023);
      for (int i = 0; i < 4; i++)
         chk($sformatf("full_rd%0d", i), radr[1][i], big_r[i]);
      chk("full_latency", dlat[1], 6146);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
